// File: rtl/sad_search_unit.sv
// sad_search_unit: full-search 8x8 SAD motion estimator with best-candidate tracking.
// Optional build macro SAD_EARLY_TERM_EN: a zero-SAD compare ends the candidate stream early.
module sad_search_unit #(
    parameter int R    = 8,
    parameter int MV_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [511:0]           cur_blk,
    input  logic                   ref_valid,
    input  logic [511:0]           ref_blk,
    output logic                   ref_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   next_block,
    output logic [13:0]            best_sad,
    output logic signed [MV_W-1:0] best_mv_x,
    output logic signed [MV_W-1:0] best_mv_y
);
    localparam int N  = (2 * R) * (2 * R);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [511:0]           cur_q;
    logic [IW-1:0]          cnt_q;
    logic                   v0_q, v1_q, v2_q, v3_q;
    logic [IW-1:0]          idx0_q, idx1_q, idx2_q, idx3_q;
    logic [511:0]           ref0_q;
    logic [511:0]           ad_q, ad_d;
    logic [87:0]            rs_q, rs_d;
    logic [13:0]            tot_q, tot_d;
    logic [13:0]            best_sad_q;
    logic signed [MV_W-1:0] mvx_q, mvy_q;
    logic signed [MV_W-1:0] mvx_d, mvy_d;
    logic                   xfer, last, better, early;

    assign xfer   = ref_valid && ref_ready;
    assign last   = cnt_q == IW'(N - 1);
    assign better = v3_q && (tot_q < best_sad_q);
    assign mvx_d  = MV_W'(idx3_q % IW'(2 * R)) - MV_W'(R);
    assign mvy_d  = MV_W'(idx3_q / IW'(2 * R)) - MV_W'(R);

`ifdef SAD_EARLY_TERM_EN
    assign early = v3_q && (tot_q == '0);
`else
    assign early = 1'b0;
`endif

    assign best_sad  = best_sad_q;
    assign best_mv_x = mvx_q;
    assign best_mv_y = mvy_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: DRAIN ends on the edge where the last in-flight candidate is compared
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = ((xfer && last) || early) ? DRAIN : RUN;
            DRAIN:   state_d = (v0_q || v1_q || v2_q) ? DRAIN : DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from state
    always_comb begin
        ref_ready  = state_q == RUN;
        busy       = state_q != IDLE;
        done       = state_q == DONE;
        next_block = state_q == DONE;
    end

    // Search context: latched current block, candidate counter and running minimum
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q      <= '0;
            cnt_q      <= '0;
            best_sad_q <= 14'h3FFF;
            mvx_q      <= '0;
            mvy_q      <= '0;
        end else if (state_q == IDLE && start) begin
            cur_q      <= cur_blk;
            cnt_q      <= '0;
            best_sad_q <= 14'h3FFF;
            mvx_q      <= '0;
            mvy_q      <= '0;
        end else begin
            if (xfer) cnt_q <= cnt_q + IW'(1);
            if (better) begin
                best_sad_q <= tot_q;
                mvx_q      <= mvx_d;
                mvy_q      <= mvy_d;
            end
        end
    end

    // SAD arithmetic: per-pixel absolute difference, row sums, block total
    always_comb begin
        ad_d  = '0;
        rs_d  = '0;
        tot_d = '0;
        for (int k = 0; k < 64; k++)
            ad_d[8*k +: 8] = (cur_q[8*k +: 8] > ref0_q[8*k +: 8]) ? cur_q[8*k +: 8] - ref0_q[8*k +: 8] : ref0_q[8*k +: 8] - cur_q[8*k +: 8];
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                rs_d[11*r +: 11] = rs_d[11*r +: 11] + 11'(ad_q[8*(8*r+c) +: 8]);
        for (int r = 0; r < 8; r++)
            tot_d = tot_d + 14'(rs_q[11*r +: 11]);
    end

    // Pipeline registers: input capture, |diff|, row sums, total, each tagged with its index
    always_ff @(posedge clk) begin
        if (!rst) begin
            {v0_q, v1_q, v2_q, v3_q}         <= '0;
            {idx0_q, idx1_q, idx2_q, idx3_q} <= '0;
            ref0_q                           <= '0;
            ad_q                             <= '0;
            rs_q                             <= '0;
            tot_q                            <= '0;
        end else begin
            v0_q <= xfer;
            if (xfer) begin
                ref0_q <= ref_blk;
                idx0_q <= cnt_q;
            end
            v1_q   <= v0_q;
            idx1_q <= idx0_q;
            ad_q   <= ad_d;
            v2_q   <= v1_q;
            idx2_q <= idx1_q;
            rs_q   <= rs_d;
            v3_q   <= v2_q;
            idx3_q <= idx2_q;
            tot_q  <= tot_d;
        end
    end
endmodule

// File: tb/tb_sad_search_unit.sv
// tb_sad_search_unit: scoreboard bench for sad_search_unit with directed search vectors.
module tb_sad_search_unit;
    localparam int N = 256;
`ifdef SAD_EARLY_TERM_EN
    localparam int T1_XF = 42;
    localparam bit ET    = 1'b1;
`else
    localparam int T1_XF = 256;
    localparam bit ET    = 1'b0;
`endif

    typedef struct {int sad; int x; int y;} exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              ref_valid = 1'b0;
    logic [511:0]      cur_blk = '0;
    logic [511:0]      ref_blk = '0;
    logic              ref_ready, busy, done, next_block;
    logic [13:0]       best_sad;
    logic signed [4:0] best_mv_x, best_mv_y;

    exp_t exp_q[$];
    exp_t e;
    int   cmp_n = 0, err_n = 0, cyc = 0;
    int   done_cnt = 0, nb_cnt = 0, done_cyc = 0;
    int   n, d0;

    sad_search_unit #(.R(8), .MV_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .cur_blk(cur_blk),
        .ref_valid(ref_valid), .ref_blk(ref_blk), .ref_ready(ref_ready),
        .busy(busy), .done(done), .next_block(next_block),
        .best_sad(best_sad), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int expv);
        cmp_n++;
        if (act != expv) begin
            err_n++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic [511:0] fill(input logic [7:0] v);
        return {64{v}};
    endfunction

    function automatic logic [511:0] cur_of(input int t);
        return (t == 3) ? fill(8'h00) : fill(8'h10);
    endfunction

    function automatic logic [511:0] ref_of(input int t, input int i);
        logic [511:0] b;
        if (t == 1)      b = (i == 37) ? fill(8'h10) : fill(8'h11);
        else if (t == 2) b = fill(8'h1A);
        else begin
            b = fill(8'hFF);
            if (i == 255) b[7:0] = 8'hFE;
        end
        return b;
    endfunction

    task automatic chk_reset(input string p);
        chk({p, "_ref_ready"}, int'(ref_ready), 0);
        chk({p, "_busy"}, int'(busy), 0);
        chk({p, "_done"}, int'(done), 0);
        chk({p, "_next_block"}, int'(next_block), 0);
        chk({p, "_best_sad"}, int'(best_sad), 16383);
        chk({p, "_mv_x"}, int'(best_mv_x), 0);
        chk({p, "_mv_y"}, int'(best_mv_y), 0);
    endtask

    // Monitor: every done pulse pops the oldest expected result
    initial forever begin
        @(negedge clk);
        if (next_block) nb_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc + 1;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("best_sad", int'(best_sad), e.sad);
                chk("best_mv_x", int'(best_mv_x), e.x);
                chk("best_mv_y", int'(best_mv_y), e.y);
                chk("next_block_with_done", int'(next_block), 1);
            end
        end
    end

    task automatic run_search(input int t, input bit gaps, input int abort_at, output int nxf);
        int  s, lst, guard, dc, idx;
        bit  xf;
        cur_blk = cur_of(t);
        start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        start = 1'b0;
        if (abort_at < 0) begin
            if (t == 1)      exp_q.push_back('{0, -3, -6});
            else if (t == 2) exp_q.push_back('{640, -8, -8});
            else             exp_q.push_back('{16319, 7, 7});
        end
        dc = done_cnt;
        idx = 0;
        lst = s;
        guard = 0;
        while (idx < N && guard < 2000) begin
            guard++;
            ref_blk = ref_of(t, idx);
            ref_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            start = (t == 2 && idx == 50);
            cur_blk = start ? fill(8'h00) : cur_of(t);
            @(negedge clk);
            if (!ref_ready) break;
            xf = ref_valid;
            @(posedge clk); #1;
            if (xf) begin
                idx++;
                lst = cyc;
            end
            if (abort_at >= 0 && idx == abort_at) break;
        end
        ref_valid = 1'b0;
        start = 1'b0;
        cur_blk = cur_of(t);
        nxf = idx;
        if (abort_at >= 0) return;
        guard = 0;
        while (done_cnt == dc && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("done_seen", done_cnt - dc, 1);
        if (!gaps || !ET) chk("done_after_last_xfer", done_cyc - lst, 5);
        if (!gaps) begin
            chk("xfer_count", nxf, (t == 1) ? T1_XF : N);
            chk("start_to_done", done_cyc - s, ((t == 1) ? T1_XF : N) + 5);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_search(1, 1'b0, -1, n);
        run_search(2, 1'b0, -1, n);
        run_search(1, 1'b1, -1, n);
        d0 = done_cnt;
        run_search(3, 1'b0, 100, n);
        chk("abort_xfers", n, 100);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("abort");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        run_search(3, 1'b0, -1, n);
        repeat (5) @(posedge clk);
        #1;
        chk("done_total", done_cnt, 4);
        chk("next_block_total", nb_cnt, 4);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
